// File: rtl/nn_pkg.sv
// Shared types and helpers for the sequential neuron: FSM state encoding
// and the saturate/clamp function used on the accumulated sum.
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_BIAS = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Working width of the clamp helper; accumulators up to this width are supported.
    localparam int unsigned SAT_W = 128;

    // ReLU (relu=1) or symmetric signed clamp (relu=0) of v into a dw-bit range.
    function automatic logic signed [SAT_W-1:0] sat_clamp(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             dw,
        input logic                    relu
    );
        logic        [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] r;
        one = SAT_W'(1);
        hi  = signed'((one << (dw - 1)) - one);
        lo  = ~hi;
        r   = v;
        if (relu && (v < 0)) begin
            r = '0;
        end else if (v > hi) begin
            r = hi;
        end else if (!relu && (v < lo)) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Neuron datapath: signed multiply-accumulate, bias add, fixed-point
// rescale and output clamp into a registered result.
module nn_mac_unit
    import nn_pkg::*;
#(
    parameter int unsigned DW      = 16,
    parameter int unsigned FRAC    = 0,
    parameter int unsigned ACC_W   = 40,
    parameter int unsigned RELU_EN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 mac_en,
    input  logic                 bias_en,
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] w,
    input  logic signed [DW-1:0] bias,
    output logic        [DW-1:0] result
);

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] shifted;

    // Full-precision product; the bias is aligned to the product's fraction point.
    assign prod    = x * w;
    assign biased  = acc + (ACC_W'(bias) <<< FRAC);
    assign shifted = biased >>> FRAC;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (clear) begin
                acc <= '0;
            end else if (mac_en) begin
                acc <= acc + ACC_W'(prod);
            end
            if (bias_en) begin
                result <= DW'(sat_clamp(SAT_W'(shifted), DW, RELU_EN != 0));
            end
        end
    end

endmodule

// File: rtl/neuron_seq_mac.sv
// Sequential single neuron: accepts an activation vector, runs one MAC per
// input, adds the bias and presents a clamped result with valid/ready.
module neuron_seq_mac
    import nn_pkg::*;
#(
    parameter int unsigned        N_IN    = 5,
    parameter int unsigned        DW      = 16,
    parameter int unsigned        FRAC    = 0,
    parameter int unsigned        ACC_W   = 40,
    parameter int unsigned        RELU_EN = 1,
    parameter logic [N_IN*DW-1:0] W_INIT  = {16'hFFEF, 16'hFFE3, 16'h001A, 16'h0011, 16'hFFFC},
    parameter logic [DW-1:0]      B_INIT  = '1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_IN*DW-1:0]           in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DW-1:0]                out_data,
    input  logic                         w_we,
    input  logic [$clog2(N_IN+1)-1:0]    w_addr,
    input  logic [DW-1:0]                w_data
);

    localparam int unsigned AW = $clog2(N_IN + 1);
    localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    state_t                state;
    logic [IW-1:0]         idx;
    logic [N_IN*DW-1:0]    x_reg;
    logic signed [DW-1:0]  weights [N_IN];
    logic signed [DW-1:0]  bias;
    logic                  accept;
    logic                  coef_we;
    logic                  mac_en;
    logic                  bias_en;

    assign accept  = in_valid && in_ready;
    assign coef_we = (state == ST_IDLE) && w_we && !accept;
    assign mac_en  = (state == ST_MAC);
    assign bias_en = (state == ST_BIAS);

    // Control FSM; x_reg shifts so the current activation always sits in the LSBs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            idx       <= '0;
            x_reg     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_MAC;
                        in_ready <= 1'b0;
                        idx      <= '0;
                        x_reg    <= in_data;
                    end
                end
                ST_MAC: begin
                    x_reg <= x_reg >> DW;
                    idx   <= idx + IW'(1);
                    if (idx == IW'(N_IN - 1)) begin
                        state <= ST_BIAS;
                    end
                end
                ST_BIAS: begin
                    state     <= ST_DONE;
                    out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Coefficient bank: writes land only while idle and not colliding with an accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < N_IN; k++) begin
                weights[k] <= W_INIT[k*DW +: DW];
            end
            bias <= B_INIT;
        end else if (coef_we) begin
            if (w_addr < AW'(N_IN)) begin
                weights[IW'(w_addr)] <= w_data;
            end else if (w_addr == AW'(N_IN)) begin
                bias <= w_data;
            end
        end
    end

    nn_mac_unit #(
        .DW      (DW),
        .FRAC    (FRAC),
        .ACC_W   (ACC_W),
        .RELU_EN (RELU_EN)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .mac_en  (mac_en),
        .bias_en (bias_en),
        .x       (x_reg[DW-1:0]),
        .w       (weights[idx]),
        .bias    (bias),
        .result  (out_data)
    );

endmodule

// File: tb/tb_neuron_seq_mac.sv
// Bench for neuron_seq_mac: ReLU and linear instances share stimulus and are
// checked against a plain-arithmetic dot-product model.
module tb_neuron_seq_mac;

    localparam int N = 5;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready_l;
    logic [79:0] in_data;
    logic        out_valid;
    logic        out_valid_l;
    logic        out_ready;
    logic [15:0] out_data;
    logic [15:0] out_data_l;
    logic        w_we;
    logic [2:0]  w_addr;
    logic [15:0] w_data;

    int vectors = 0;
    int miscompares = 0;

    int mw [N];
    int mb;

    typedef struct packed {
        logic [79:0] d;
        logic [15:0] er;
        logic [15:0] el;
    } vec_t;

    vec_t tbl [8];

    neuron_seq_mac dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data)
    );

    neuron_seq_mac #(.RELU_EN(0)) dut_lin (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready_l),
        .in_data   (in_data),
        .out_valid (out_valid_l),
        .out_ready (out_ready),
        .out_data  (out_data_l),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [79:0] pack5(input int a, input int b, input int c, input int d, input int e);
        return {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [79:0] rnd80();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[79:0];
    endfunction

    task automatic model_reset();
        mw[0] = -4; mw[1] = 17; mw[2] = 26; mw[3] = -29; mw[4] = -17;
        mb = -1;
    endtask

    // Dot product plus bias, then ReLU/saturate and signed clamp to 16 bits.
    task automatic model(input logic [79:0] d, output logic [15:0] er, output logic [15:0] el);
        longint s;
        s = longint'(mb);
        for (int i = 0; i < N; i++) begin
            s += longint'($signed(d[i*16 +: 16])) * longint'(mw[i]);
        end
        if (s < 0)              er = 16'h0000;
        else if (s > 32767)     er = 16'h7FFF;
        else                    er = 16'(s);
        if (s > 32767)          el = 16'h7FFF;
        else if (s < -32768)    el = 16'h8000;
        else                    el = 16'(s);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] dat);
        @(negedge clk);
        w_we = 1'b1; w_addr = a; w_data = dat;
        @(negedge clk);
        w_we = 1'b0;
        if (a < 3'(N))       mw[a] = int'($signed(dat));
        else if (a == 3'(N)) mb = int'($signed(dat));
    endtask

    // wmode: 0 none, 1 coefficient write in the accept cycle, 2 write during MAC.
    task automatic send(input logic [79:0] d, input int hold, input int wmode,
                        input logic [15:0] er, input logic [15:0] el);
        int n;
        int lat;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", 64'(in_ready), 64'(1));
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = (hold == 0);
        if (wmode == 1) begin
            w_we = 1'b1; w_addr = 3'd0; w_data = 16'd10;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        w_we     = 1'b0;
        in_data  = rnd80();
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (wmode == 2 && lat == 1) begin
                w_we = 1'b1; w_addr = 3'd0; w_data = 16'd10;
            end else begin
                w_we = 1'b0;
            end
            if (lat == 3) in_data = rnd80();
        end while (!out_valid && lat < 40);
        check("latency", 64'(lat), 64'(N + 2));
        check("data_relu", 64'(out_data), 64'(er));
        check("data_lin", 64'(out_data_l), 64'(el));
        check("done_in_ready", 64'(in_ready), 64'(0));
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            in_data  = rnd80();
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_relu", 64'(out_data), 64'(er));
            check("hold_lin", 64'(out_data_l), 64'(el));
            check("hold_in_ready", 64'(in_ready), 64'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("back_idle", 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    initial begin
        logic [79:0] d;
        logic [15:0] er;
        logic [15:0] el;
        int n;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        w_we = 1'b0; w_addr = '0; w_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'({out_valid, out_valid_l}), 64'(0));
        check("rst_in_ready", 64'({in_ready, in_ready_l}), 64'(2'b11));
        check("rst_out_data", 64'({out_data, out_data_l}), 64'(0));
        reset = 1'b0;

        // Default weights (-4,17,26,-29,-17), bias -1.
        tbl[0] = '{pack5(0, 1, 1, 0, 0),          16'd42,   16'd42};
        tbl[1] = '{pack5(1, 1, 1, 1, 1),          16'h0000, 16'hFFF8};
        tbl[2] = '{pack5(0, 0, 32767, 0, 0),      16'h7FFF, 16'h7FFF};
        tbl[3] = '{pack5(0, 0, -32768, 0, 0),     16'h0000, 16'h8000};
        tbl[4] = '{pack5(0, 0, 0, 0, 0),          16'h0000, 16'hFFFF};
        tbl[5] = '{pack5(1, 0, 0, 0, 0),          16'h0000, 16'hFFFB};
        tbl[6] = '{pack5(0, 1, 0, 0, 0),          16'd16,   16'd16};
        tbl[7] = '{pack5(2, 0, 0, 0, -1),         16'd8,    16'd8};
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].d, 0, 0, tbl[i].er, tbl[i].el);
        end

        // Output held for three cycles under backpressure.
        send(pack5(0, 1, 1, 0, 0), 3, 0, 16'd42, 16'd42);

        // Idle write takes effect; writes during MAC or the accept cycle are dropped.
        wr(3'd0, 16'd10);
        send(pack5(1, 0, 0, 0, 0), 0, 0, 16'd9, 16'd9);
        wr(3'd0, 16'hFFFC);
        send(pack5(1, 0, 0, 0, 0), 0, 2, 16'h0000, 16'hFFFB);
        send(pack5(1, 0, 0, 0, 0), 0, 1, 16'h0000, 16'hFFFB);

        // Bias write, and out-of-range addresses ignored.
        wr(3'd5, 16'd100);
        wr(3'd6, 16'd555);
        wr(3'd7, 16'd777);
        send(pack5(0, 0, 0, 0, 0), 0, 0, 16'd100, 16'd100);
        wr(3'd5, 16'hFFFF);

        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) wr(3'($urandom_range(0, 7)), 16'($urandom));
                else                           wr(3'($urandom_range(0, 7)), 16'($urandom_range(0, 128) - 64));
            end
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1) d[i*16 +: 16] = 16'($urandom);
                else                           d[i*16 +: 16] = 16'($urandom_range(0, 16) - 8);
            end
            model(d, er, el);
            send(d, int'($urandom_range(0, 2)), 0, er, el);
        end

        // Reset during the third MAC cycle discards the result and restores coefficients.
        wr(3'd0, 16'd10);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = pack5(1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_out_valid", 64'({out_valid, out_valid_l}), 64'(0));
        check("midrst_in_ready", 64'({in_ready, in_ready_l}), 64'(2'b11));
        check("midrst_out_data", 64'({out_data, out_data_l}), 64'(0));
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid || out_valid_l) n++;
        end
        check("no_stale_valid", 64'(n), 64'(0));
        model_reset();
        send(pack5(1, 0, 0, 0, 0), 0, 0, 16'h0000, 16'hFFFB);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
